// File: rtl/fixed_power.sv
// ---------------------------------------------------------------------------
// fixed_power
//
// Iterative unsigned fixed-point power unit: out = x^k, where x is WIDTH-bit
// unsigned with FRAC fractional bits (10.10 by default) and k is a 3-bit
// integer exponent. A single WIDTHxWIDTH multiplier is reused once per cycle
// for k cycles. Results that exceed the format saturate to all-ones. The
// saturation flag is sticky for the rest of the operation.
//
// Optional build macro:
//   POW_ROUND_EN  - each multiply step rounds to nearest instead of truncating.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset (aborts any operation silently)
//   in_valid   operand strobe, only sampled while idle
//   in_data_1  operand x, unsigned WIDTH-bit fixed point
//   in_data_2  exponent k, 0..7
//   busy       high while an operation is in flight (state != idle)
//   out_valid  one-cycle result strobe
//   out_data   x^k, zero when out_valid is low
//   out_ovf    saturation flag, zero when out_valid is low
// ---------------------------------------------------------------------------
module fixed_power #(
  parameter int WIDTH = 20,
  parameter int FRAC  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [2:0]       in_data_2,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_OUT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [2:0]       cnt;
  logic             ovf;
  logic [WIDTH-1:0] x_q;
  logic [2:0]       k_q;

  // Rescale a full-width product back to the operand format and saturate.
  // Returns {overflow, value}; value is all-ones whenever overflow is set.
  function automatic logic [WIDTH:0] scale_sat(input logic [2*WIDTH-1:0] prod);
    logic [2*WIDTH:0] p;
    logic [2*WIDTH:0] sh;
    p = {1'b0, prod};
`ifdef POW_ROUND_EN
    p = p + ((2*WIDTH+1)'(1) << (FRAC - 1));
`endif
    sh = p >> FRAC;
    if (sh > {{(WIDTH+1){1'b0}}, MAXV}) begin
      return {1'b1, MAXV};
    end
    return {1'b0, sh[WIDTH-1:0]};
  endfunction

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     step;
  logic               step_ovf;
  logic [WIDTH-1:0]   step_val;
  logic               last_step;

  assign prod      = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_q};
  assign step      = scale_sat(prod);
  assign step_ovf  = ovf | step[WIDTH];
  assign step_val  = step[WIDTH-1:0];
  assign last_step = (cnt == (k_q - 3'd1));

  // Operand latches: only written on acceptance, so in_valid while busy
  // can never disturb the operation in flight.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      x_q <= in_data_1;
      k_q <= in_data_2;
    end
  end

  // Control FSM. Outputs are registered on the same edge that enters
  // ST_OUT, so out_valid is high exactly while the state is ST_OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc  <= ONE;
            cnt  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b1;
            if (in_data_2 != 3'd0) begin
              state <= ST_MUL;
            end else begin
              // x^0 is 1.0 regardless of x, including x == 0
              state     <= ST_OUT;
              out_valid <= 1'b1;
              out_data  <= ONE;
            end
          end
        end
        ST_MUL: begin
          acc <= step_val;
          ovf <= step_ovf;
          cnt <= cnt + 3'd1;
          if (last_step) begin
            state     <= ST_OUT;
            out_valid <= 1'b1;
            // sticky: once saturated, the result stays at full scale
            out_data  <= step_ovf ? MAXV : step_val;
            out_ovf   <= step_ovf;
          end
        end
        ST_OUT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_power.sv
module tb_fixed_power;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_data_1;
  logic [2:0]  in_data_2;
  logic        busy;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  fixed_power #(.WIDTH(20), .FRAC(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation at a negedge, then measure latency and result.
  task automatic run_op(input string tag, input logic [19:0] x, input logic [2:0] k,
                        input logic [19:0] exp_data, input logic exp_ovf);
    int n;
    int busy_low;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = x;
    in_data_2 = k;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data_1 = 20'h0;
    in_data_2 = 3'd0;
    n = 1;
    busy_low = 0;
    while (!out_valid && n < 20) begin
      if (!busy) busy_low++;
      @(negedge clk);
      n++;
    end
    if (!busy) busy_low++;
    check({tag, "_lat"}, n, int'(k) + 1);
    check({tag, "_busy"}, busy_low, 0);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_ovf"}, out_ovf, exp_ovf);
    @(negedge clk);
    check({tag, "_vld_drop"}, {out_valid, busy, out_ovf}, 3'b000);
    check({tag, "_data_zero"}, out_data, 20'h0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [19:0] got_data;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data_1 = 20'h0;
    in_data_2 = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_outs", {busy, out_valid, out_ovf}, 3'b000);
    check("reset_data", out_data, 20'h0);
    rst = 1'b0;

    run_op("pow_2_3",    20'h00800, 3'd3, 20'h02000, 1'b0);
    run_op("pow_1p5_2",  20'h00600, 3'd2, 20'h00900, 1'b0);
    run_op("k0_x12345",  20'h12345, 3'd0, 20'h00400, 1'b0);
    run_op("k0_x0",      20'h00000, 3'd0, 20'h00400, 1'b0);
    run_op("x0_k1",      20'h00000, 3'd1, 20'h00000, 1'b0);
    run_op("x0_k7",      20'h00000, 3'd7, 20'h00000, 1'b0);
    run_op("half_2",     20'h00200, 3'd2, 20'h00100, 1'b0);
    run_op("one_7",      20'h00400, 3'd7, 20'h00400, 1'b0);
    run_op("sat_32_2",   20'h08000, 3'd2, 20'hFFFFF, 1'b1);
    run_op("sat_sticky", 20'h0FFFF, 3'd7, 20'hFFFFF, 1'b1);
    run_op("big_1",      20'hFFFFF, 3'd1, 20'hFFFFF, 1'b0);
`ifdef POW_ROUND_EN
    run_op("round_417",  20'h00417, 3'd2, 20'h0042F, 1'b0);
`else
    run_op("trunc_417",  20'h00417, 3'd2, 20'h0042E, 1'b0);
`endif

    // in_valid held high with changing data for a whole k=5 operation,
    // including the ST_OUT cycle; only the first operand may be used.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = 20'h00800;
    in_data_2 = 3'd5;
    n = 0;
    pulses = 0;
    got_data = 20'h0;
    while (pulses == 0 && n < 20) begin
      @(negedge clk);
      n++;
      in_data_1 = 20'h00600 + 20'(n);
      in_data_2 = 3'(n % 3);
      if (out_valid) begin
        pulses++;
        got_data = out_data;
      end
    end
    check("hold_lat", n, 6);
    check("hold_data", got_data, 20'h08000);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_out_ignored", {busy, out_valid}, 2'b00);
    // accepted right after the out_valid cycle
    run_op("after_hold", 20'h00600, 3'd2, 20'h00900, 1'b0);

    // Reset in the middle of a k=5 operation
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = 20'h00800;
    in_data_2 = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outs", {busy, out_valid, out_ovf}, 3'b000);
    check("midrst_data", out_data, 20'h0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    run_op("after_rst", 20'h00800, 3'd3, 20'h02000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_power.md
Name: fixed_power

Overview:
- Iterative fixed-point power unit: computes x^k for unsigned 10.10 fixed-point x and a 3-bit integer exponent k.
- Inverse companion of the root unit. It takes a root result (20-bit, 10.10) plus the same exponent and reconstructs the power. Verification uses it to close the loop root -> power.
- One shared 20x20 multiplier is reused for k cycles, sequenced by a small FSM.

Parameters:
- WIDTH, 20, data width of operand and result (unsigned fixed point).
- FRAC, 10, number of fractional bits; 1.0 is encoded as 1<<FRAC (20'h00400).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand strobe; sampled only in ST_IDLE.
- in_data_1  input  20  operand x, unsigned 10.10.
- in_data_2  input  3  exponent k, 0..7.
- busy  output  1  high whenever state != ST_IDLE.
- out_valid  output  1  one-cycle result strobe.
- out_data  output  20  result x^k, unsigned 10.10; 0 when out_valid is low.
- out_ovf  output  1  saturation flag, qualified by out_valid; 0 otherwise.

Behaviour:
- Reset (rst=1 at posedge) forces the following, including mid-operation; any in-flight computation is discarded with no out_valid:
  - state=ST_IDLE
  - out_valid=0, out_data=0, out_ovf=0, busy=0
  - acc=0, cnt=0, ovf=0
- All outputs are registered.
- States: ST_IDLE, ST_MUL, ST_OUT.
- ST_IDLE, in_valid=1:
  - Latch x<=in_data_1, k<=in_data_2.
  - acc<=20'h00400, cnt<=0, ovf<=0.
  - Next state ST_MUL if k!=0, else ST_OUT.
  - in_valid=0: stay in ST_IDLE.
- ST_MUL, each cycle:
  - prod = acc*x, 40 bits.
  - sh = prod>>FRAC (truncation).
  - If sh > 20'hFFFFF: acc<=20'hFFFFF, ovf<=1 (sticky). Else acc<=sh[19:0].
  - cnt<=cnt+1.
  - When cnt==k-1, next state ST_OUT.
- ST_OUT:
  - Drives out_valid=1 for exactly one cycle.
  - out_data = ovf ? 20'hFFFFF : acc. Saturation is sticky even if later multiplies by x<1 shrink acc.
  - out_ovf=ovf.
  - Next state ST_IDLE.
- Latency: in_valid accepted at edge T -> out_valid high in cycle T+k+1 (k=0: T+1).
  - Throughput is one operation per k+2 cycles.
- in_valid while busy=1 (including ST_OUT): ignored. The operand is not queued, and latched x/k do not change.
- in_valid in the cycle immediately after out_valid (state back in ST_IDLE) is accepted.
- x=0, k>=1: result 0, no overflow.
- x=0, k=0: result 20'h00400.
- Arithmetic is unsigned throughout; no negative values.

Optional Feature:
- Macro POW_ROUND_EN.
- Defined: each ST_MUL step rounds to nearest, sh=(prod+(1<<(FRAC-1)))>>FRAC. Overflow check applies after rounding.
- Undefined: truncation as above.
- Latency and interface are identical in both builds.

Test Plan:
- x=20'h00800 (2.0), k=3 -> out_valid at T+4, out_data=20'h02000 (8.0), out_ovf=0; busy high T+1..T+4.
- x=20'h00600 (1.5), k=2 -> out_data=20'h00900 (2.25) at T+3.
- k=0 for x=20'h12345 and x=0 -> out_data=20'h00400 at T+1.
- k=1, x=20'h00000 -> out_data=0 at T+2, out_ovf=0.
- x=20'h08000 (32.0), k=2 -> out_data=20'hFFFFF, out_ovf=1.
- Sticky saturation: x=20'h0FFFF, k=7 -> out_data=20'hFFFFF, out_ovf=1.
- x=20'h00417, k=2:
  - Without POW_ROUND_EN -> 20'h0042E.
  - With POW_ROUND_EN -> 20'h0042F.
- Robustness:
  - Assert in_valid continuously with changing data during a k=5 operation -> only the first operand is processed and one out_valid pulse is produced.
  - Assert rst=1 at T+2 of a k=5 operation -> no out_valid, all outputs 0 next cycle, and the next in_valid is accepted normally.
